// File: rtl/easyaxi_rd_beat_gen.sv
// easyaxi_rd_beat_gen: turns queued {id, addr, len} read commands into AXI R beats whose data is the beat address
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   cmd_empty/cmd_data  command FIFO status and head entry {id, addr, len}
//   cmd_rd             pops the FIFO head on the current edge
//   rvalid/rready      R channel handshake
//   rid/rdata/rresp/rlast R beat fields
//   busy               a burst is in progress
//   burst_cnt          completed bursts, wrapping at 2^16
module easyaxi_rd_beat_gen #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_empty,
  input  logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH-1:0] cmd_data,
  output logic                                    cmd_rd,
  output logic                                    rvalid,
  input  logic                                    rready,
  output logic [ID_WIDTH-1:0]                     rid,
  output logic [DATA_WIDTH-1:0]                   rdata,
  output logic [1:0]                              rresp,
  output logic                                    rlast,
  output logic                                    busy,
  output logic [15:0]                             burst_cnt
);
  localparam int cw = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] beat_bytes = ADDR_WIDTH'(DATA_WIDTH / 8);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  hs;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    rvalid  = state == BURST;
    busy    = rvalid;
    rlast   = rvalid && beat_cnt == len_q;
    hs      = rvalid && rready;
    // a pop either starts from idle or chains straight off the final beat
    cmd_rd  = !rst && !cmd_empty && (!rvalid || (hs && rlast));
    state_n = !rvalid ? (cmd_empty ? IDLE : BURST) : (hs && rlast && cmd_empty ? IDLE : BURST);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if (cmd_rd) begin
        id_q     <= cmd_data[cw-1 -: ID_WIDTH];
        addr_q   <= cmd_data[LEN_WIDTH +: ADDR_WIDTH];
        len_q    <= cmd_data[LEN_WIDTH-1:0];
        beat_cnt <= '0;
      end else if (hs && !rlast) begin
        beat_cnt <= beat_cnt + 1'b1;
        addr_q   <= addr_q + beat_bytes;
      end
      if (hs && rlast) burst_cnt <= burst_cnt + 16'd1;
    end
  assign rid   = id_q;
  assign rdata = DATA_WIDTH'(addr_q);
  assign rresp = 2'b00;
endmodule

// File: tb/tb_easyaxi_rd_beat_gen.sv
// tb_easyaxi_rd_beat_gen: table-driven and directed checks of the read beat generator
module tb_easyaxi_rd_beat_gen;
  logic        clk = 1'b0;
  logic        rst, cmd_empty, rready, cmd_rd, rvalid, rlast, busy;
  logic [43:0] cmd_data;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [15:0] burst_cnt;
  logic        popped = 1'b0;
  logic [43:0] q[$];
  int          n_vec = 0, n_err = 0;
  typedef struct {
    logic        rst;
    logic        push;
    logic [43:0] cmd;
    logic        rready;
    logic        e_rvalid;
    logic        e_rlast;
    logic        e_cmd_rd;
    logic [3:0]  e_rid;
    logic [31:0] e_rdata;
    logic [15:0] e_bcnt;
  } vec_t;
  vec_t v[28];
  easyaxi_rd_beat_gen dut (
    .clk(clk), .rst(rst), .cmd_empty(cmd_empty), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .busy(busy), .burst_cnt(burst_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) popped <= cmd_rd;
  function automatic logic [43:0] mk(logic [3:0] id, logic [31:0] a, logic [7:0] l);
    return {id, a, l};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic upd();
    cmd_empty = q.size() == 0;
    cmd_data  = cmd_empty ? '0 : q[0];
  endtask
  task automatic next();
    @(negedge clk);
    if (popped) begin
      chk("pop_from_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) void'(q.pop_front());
    end
  endtask
  initial begin
    int beats;
    logic [31:0] last_data;
    rst = 1'b0; rready = 1'b1; cmd_empty = 1'b1; cmd_data = '0;
    #1 rst = 1'b1;
    v[0]  = '{1, 0, '0, 1, 0, 0, 0, 4'd0, 32'h0, 16'd0};
    v[1]  = '{0, 1, mk(3, 32'h100, 3), 1, 0, 0, 1, 4'd0, 32'h0, 16'd0};
    v[2]  = '{0, 0, '0, 1, 1, 0, 0, 4'd3, 32'h100, 16'd0};
    v[3]  = '{0, 0, '0, 1, 1, 0, 0, 4'd3, 32'h104, 16'd0};
    v[4]  = '{0, 0, '0, 1, 1, 0, 0, 4'd3, 32'h108, 16'd0};
    v[5]  = '{0, 0, '0, 1, 1, 1, 0, 4'd3, 32'h10C, 16'd0};
    v[6]  = '{0, 0, '0, 1, 0, 0, 0, 4'd0, 32'h0, 16'd1};
    v[7]  = '{0, 1, mk(0, 32'hFFFFFFFC, 0), 1, 0, 0, 1, 4'd0, 32'h0, 16'd1};
    v[8]  = '{0, 1, mk(0, 32'hFFFFFFFC, 1), 1, 1, 1, 1, 4'd0, 32'hFFFFFFFC, 16'd1};
    v[9]  = '{0, 0, '0, 1, 1, 0, 0, 4'd0, 32'hFFFFFFFC, 16'd2};
    v[10] = '{0, 0, '0, 1, 1, 1, 0, 4'd0, 32'h00000000, 16'd2};
    v[11] = '{0, 0, '0, 1, 0, 0, 0, 4'd0, 32'h0, 16'd3};
    v[12] = '{0, 1, mk(1, 32'h200, 1), 1, 0, 0, 1, 4'd0, 32'h0, 16'd3};
    v[13] = '{0, 1, mk(2, 32'h300, 2), 1, 1, 0, 0, 4'd1, 32'h200, 16'd3};
    v[14] = '{0, 0, '0, 1, 1, 1, 1, 4'd1, 32'h204, 16'd3};
    v[15] = '{0, 0, '0, 1, 1, 0, 0, 4'd2, 32'h300, 16'd4};
    v[16] = '{0, 0, '0, 1, 1, 0, 0, 4'd2, 32'h304, 16'd4};
    v[17] = '{0, 0, '0, 1, 1, 1, 0, 4'd2, 32'h308, 16'd4};
    v[18] = '{0, 0, '0, 1, 0, 0, 0, 4'd0, 32'h0, 16'd5};
    v[19] = '{0, 1, mk(5, 32'h400, 3), 1, 0, 0, 1, 4'd0, 32'h0, 16'd5};
    v[20] = '{0, 0, '0, 1, 1, 0, 0, 4'd5, 32'h400, 16'd5};
    v[21] = '{0, 0, '0, 0, 1, 0, 0, 4'd5, 32'h404, 16'd5};
    v[22] = '{0, 0, '0, 0, 1, 0, 0, 4'd5, 32'h404, 16'd5};
    v[23] = '{0, 0, '0, 1, 1, 0, 0, 4'd5, 32'h404, 16'd5};
    v[24] = '{0, 0, '0, 0, 1, 0, 0, 4'd5, 32'h408, 16'd5};
    v[25] = '{0, 0, '0, 1, 1, 0, 0, 4'd5, 32'h408, 16'd5};
    v[26] = '{0, 0, '0, 1, 1, 1, 0, 4'd5, 32'h40C, 16'd5};
    v[27] = '{0, 0, '0, 1, 0, 0, 0, 4'd0, 32'h0, 16'd6};
    foreach (v[i]) begin
      next();
      if (v[i].push) q.push_back(v[i].cmd);
      rst = v[i].rst;
      rready = v[i].rready;
      upd();
      #1;
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(v[i].e_rvalid));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(v[i].e_rvalid));
      chk($sformatf("v%0d rlast", i), 32'(rlast), 32'(v[i].e_rlast));
      chk($sformatf("v%0d cmd_rd", i), 32'(cmd_rd), 32'(v[i].e_cmd_rd));
      chk($sformatf("v%0d burst_cnt", i), 32'(burst_cnt), 32'(v[i].e_bcnt));
      chk($sformatf("v%0d rresp", i), 32'(rresp), 32'd0);
      if (v[i].e_rvalid || v[i].rst) begin
        chk($sformatf("v%0d rid", i), 32'(rid), 32'(v[i].e_rid));
        chk($sformatf("v%0d rdata", i), rdata, v[i].e_rdata);
      end
    end
    next();
    q.push_back(mk(7, 32'h800, 7));
    q.push_back(mk(6, 32'h900, 0));
    upd();
    #1 chk("rst_seq pop1", 32'(cmd_rd), 32'd1);
    next(); upd();
    #1 chk("rst_seq beat0", rdata, 32'h800);
    chk("rst_seq rid0", 32'(rid), 32'd7);
    next(); upd();
    #1 chk("rst_seq beat1", rdata, 32'h804);
    next(); upd();
    #1 chk("rst_seq beat2", rdata, 32'h808);
    rst = 1'b1;
    #1 chk("rst_seq rvalid", 32'(rvalid), 32'd0);
    chk("rst_seq burst_cnt", 32'(burst_cnt), 32'd0);
    chk("rst_seq busy", 32'(busy), 32'd0);
    chk("rst_seq rlast", 32'(rlast), 32'd0);
    chk("rst_seq rid", 32'(rid), 32'd0);
    chk("rst_seq rdata", rdata, 32'h0);
    chk("rst_seq cmd_rd", 32'(cmd_rd), 32'd0);
    next(); upd();
    #1 chk("rst_seq cmd_rd_held", 32'(cmd_rd), 32'd0);
    chk("rst_seq queue_kept", 32'(q.size()), 32'd1);
    rst = 1'b0;
    #1 chk("rst_seq pop2", 32'(cmd_rd), 32'd1);
    next(); upd();
    #1 chk("rst_seq next_rid", 32'(rid), 32'd6);
    chk("rst_seq next_rdata", rdata, 32'h900);
    chk("rst_seq next_rlast", 32'(rlast), 32'd1);
    chk("rst_seq queue_empty", 32'(q.size()), 32'd0);
    next(); upd();
    #1 chk("rst_seq idle", 32'(rvalid), 32'd0);
    chk("rst_seq burst_cnt_after", 32'(burst_cnt), 32'd1);
    next();
    q.push_back(mk(9, 32'h1000, 255));
    upd();
    #1 chk("long pop", 32'(cmd_rd), 32'd1);
    beats = 0;
    last_data = '0;
    for (int c = 0; c < 400 && beats < 256; c++) begin
      next(); upd();
      #1;
      if (rvalid) begin
        chk($sformatf("long rdata%0d", beats), rdata, 32'h1000 + 32'(beats) * 4);
        chk($sformatf("long rlast%0d", beats), 32'(rlast), 32'(beats == 255));
        last_data = rdata;
        beats++;
      end
    end
    chk("long beats", 32'(beats), 32'd256);
    chk("long final_rdata", last_data, 32'h13FC);
    next(); upd();
    #1 chk("long idle", 32'(rvalid), 32'd0);
    chk("long burst_cnt", 32'(burst_cnt), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
